// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, sequencer FSM states and opcode classification helpers.
// Shared with the ALU so both ends of the opcode interface use one definition.
package alu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [1:0] {IDLE, EXEC, WB_LO, WB_HI} state_t;

    // MUL and DIV produce a meaningful high word and return two beats
    function automatic logic is_wide(input logic [4:0] op);
        return op == OP_MUL || op == OP_DIV;
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        return op inside {OP_LD, OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR,
                          OP_ROL, OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT};
    endfunction

endpackage

// File: rtl/alu_result_sequencer.sv
// alu_result_sequencer: issues one ALU op per request and returns Zlow (and Zhigh for MUL/DIV) as beats.
// Ports: clock/clear (async active-low reset); req_valid/req_ready/req_op/req_b request channel;
// alu_opcode/alu_zlow/alu_zhigh ALU interface; out_valid/out_ready/out_data/out_sel/out_last result
// channel; err_div0/err_illegal one-cycle error pulses.
module alu_result_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [DATA_W-1:0] req_b,
    output logic [4:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_zlow,
    input  logic [DATA_W-1:0] alu_zhigh,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sel,
    output logic              out_last,
    output logic              err_div0,
    output logic              err_illegal
);

    state_t            state, state_n;
    logic [4:0]        op_q;
    logic              wide_q;
    logic [DATA_W-1:0] z_lo_q, z_hi_q;
    logic              err_div0_q, err_ill_q;
    logic              accept, legal, div0, fast;

    assign accept = state == IDLE && req_valid;
    assign legal  = is_legal(req_op);
    assign div0   = req_op == OP_DIV && req_b == '0;
    // error requests bypass the ALU and return zeros directly
    assign fast   = !legal || div0;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid) state_n = fast ? WB_LO : EXEC;
            EXEC:    state_n = WB_LO;
            WB_LO:   if (out_ready) state_n = wide_q ? WB_HI : IDLE;
            WB_HI:   if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign req_ready   = state == IDLE;
    assign alu_opcode  = state == EXEC ? op_q : OP_LD;
    assign out_valid   = state == WB_LO || state == WB_HI;
    assign out_data    = state == WB_LO ? z_lo_q : state == WB_HI ? z_hi_q : '0;
    assign out_sel     = state == WB_HI;
    assign out_last    = (state == WB_LO && !wide_q) || state == WB_HI;
    assign err_div0    = err_div0_q;
    assign err_illegal = err_ill_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state      <= IDLE;
            op_q       <= '0;
            wide_q     <= 1'b0;
            z_lo_q     <= '0;
            z_hi_q     <= '0;
            err_div0_q <= 1'b0;
            err_ill_q  <= 1'b0;
        end else begin
            state      <= state_n;
            err_div0_q <= accept && div0;
            err_ill_q  <= accept && !legal;
            if (accept) begin
                op_q   <= req_op;
                wide_q <= legal && is_wide(req_op);
                if (fast) begin
                    z_lo_q <= '0;
                    z_hi_q <= '0;
                end
            end
            if (state == EXEC) begin
                z_lo_q <= alu_zlow;
                // zero the high word for one-beat ops so stale Zhigh never leaks out
                z_hi_q <= wide_q ? alu_zhigh : '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_sequencer.sv
// tb_alu_result_sequencer: scoreboard bench with a behavioural ALU behind the sequencer.
module tb_alu_result_sequencer;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         clear = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [4:0]   req_op = '0;
    logic [W-1:0] a_reg = '0, b_reg = '0;
    logic [4:0]   alu_opcode;
    logic [W-1:0] zl, zh;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_sel, out_last, err_div0, err_illegal;
    logic [63:0]  prod;

    alu_result_sequencer #(.DATA_W(W)) dut (
        .clock(clock), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_b(b_reg),
        .alu_opcode(alu_opcode), .alu_zlow(zl), .alu_zhigh(zh),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sel(out_sel), .out_last(out_last),
        .err_div0(err_div0), .err_illegal(err_illegal)
    );

    always #5 clock = ~clock;

    always_comb begin
        prod = 64'(a_reg) * 64'(b_reg);
        zl = '0;
        zh = '0;
        case (alu_opcode)
            OP_LD:   zl = b_reg;
            OP_ADD:  zl = a_reg + b_reg;
            OP_SUB:  zl = a_reg - b_reg;
            OP_SHR:  zl = a_reg >> b_reg[4:0];
            OP_SHRA: zl = $signed(a_reg) >>> b_reg[4:0];
            OP_SHL:  zl = a_reg << b_reg[4:0];
            OP_AND:  zl = a_reg & b_reg;
            OP_OR:   zl = a_reg | b_reg;
            OP_MUL:  begin zl = prod[31:0]; zh = prod[63:32]; end
            OP_DIV:  if (b_reg != '0) begin zl = a_reg / b_reg; zh = a_reg % b_reg; end
            OP_NEG:  zl = -b_reg;
            OP_NOT:  zl = ~b_reg;
            default: begin zl = 32'hDEAD_BEEF; zh = 32'hDEAD_BEEF; end
        endcase
    end

    typedef struct {
        logic [W-1:0] data;
        logic         sel;
        logic         last;
        int           lat;
        int           c;
    } beat_t;

    beat_t sb[$];
    int    n_chk = 0, n_fail = 0, cyc = 0;
    bit    seen = 0, saw_div = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares the presented beat against the scoreboard head every valid cycle,
    // which also proves the beat stays stable while stalled.
    always @(negedge clock) begin
        if (alu_opcode == OP_DIV) saw_div = 1;
        if (clear && out_valid) begin
            if (sb.size() == 0) chk("unexpected_beat", 1, 0);
            else begin
                if (!seen && sb[0].lat >= 0) chk("latency", cyc - sb[0].c, sb[0].lat);
                seen = 1;
                chk("out_data", out_data, sb[0].data);
                chk("out_sel", out_sel, sb[0].sel);
                chk("out_last", out_last, sb[0].last);
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 0;
                end
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] lo, input logic [W-1:0] hi,
                         input bit e_div0, input bit e_ill);
        int t = 0;
        bit wide;
        int lat;
        while (!req_ready && t < 50) begin @(posedge clock); #1; t++; end
        if (!req_ready) begin chk("req_ready_timeout", 0, 1); return; end
        wide = !e_ill && (op == OP_MUL || op == OP_DIV);
        lat = (e_div0 || e_ill) ? 1 : 2;
        a_reg = a; b_reg = b; req_op = op; req_valid = 1'b1;
        sb.push_back('{lo, 1'b0, !wide, lat, cyc});
        if (wide) sb.push_back('{hi, 1'b1, 1'b1, -1, 0});
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("err_div0_pulse", err_div0, e_div0);
        chk("err_illegal_pulse", err_illegal, e_ill);
        @(posedge clock); #1;
        chk("err_div0_clear", err_div0, 0);
        chk("err_illegal_clear", err_illegal, 0);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin @(posedge clock); #1; t++; end
        if (sb.size() != 0) chk("drain_timeout", 0, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_sel"}, out_sel, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_err_div0"}, err_div0, 0);
        chk({tag, "_err_illegal"}, err_illegal, 0);
        chk({tag, "_alu_opcode"}, alu_opcode, OP_LD);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk_reset_outputs("reset");
        clear = 1'b1;
        @(posedge clock); #1;

        issue(OP_ADD, 32'd7, 32'd5, 32'h0000_000C, 32'h0, 0, 0);
        drain();

        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 0, 0);
        drain();

        saw_div = 0;
        issue(OP_DIV, 32'd9, 32'd0, 32'h0, 32'h0, 1, 0);
        drain();
        chk("div0_never_sent", saw_div, 0);

        out_ready = 1'b0;
        issue(OP_SHL, 32'd1, 32'd4, 32'h0000_0010, 32'h0, 0, 0);
        repeat (5) begin
            chk("stall_req_ready", req_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        drain();

        out_ready = 1'b0;
        issue(OP_DIV, 32'd20, 32'd3, 32'd6, 32'd2, 0, 0);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        @(negedge clock);
        chk("wbhi_sel", out_sel, 1);
        chk("wbhi_data", out_data, 32'd2);
        #2;
        clear = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        sb.delete();
        seen = 0;
        @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        out_ready = 1'b1;
        @(posedge clock); #1;
        issue(OP_ADD, 32'h0000_0100, 32'h0000_0023, 32'h0000_0123, 32'h0, 0, 0);
        drain();

        issue(5'b11111, 32'd1, 32'd2, 32'h0, 32'h0, 0, 1);
        issue(OP_SUB, 32'd10, 32'd3, 32'h0000_0007, 32'h0, 0, 0);
        drain();

        repeat (3) @(posedge clock);
        #1;
        chk("final_idle", req_ready, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
